// File: rtl/cross_bar_pkg.sv
// Shared crossbar widths and bus types used by masters, slaves and verification models.
package cross_bar_pkg;
    localparam int SLAVE_W = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/tb_vip_slave_ws.sv
// Memory-backed crossbar slave model that inserts fixed or pseudo-random wait states before each ack.
// Latency: ack is sampled high W+1 edges after capture (W = 0..MAX_WAIT); requester holds req until ack.
module tb_vip_slave_ws
    import cross_bar_pkg::*;
#(
    parameter int          MEM_AW    = 8,
    parameter int          MAX_WAIT  = 3,
    parameter bit          RAND_EN   = 1'b0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slave_req,
    input  addr_t            slave_addr,
    input  logic             slave_cmd,
    input  data_t            slave_wdata,
    output logic             slave_ack,
    output data_t            slave_rdata,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [4:0] MW = 5'(MAX_WAIT);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic [4:0]  w_rand;
    logic [3:0]  w_sel;
    logic        capture, enter_ack, drop;

    logic [MEM_AW-1:0] mem_idx;
    data_t             mem [0:(1<<MEM_AW)-1];

    assign mem_idx   = slave_addr[MEM_AW-1:0];
    assign slave_ack = (state == S_ACK);

    // x^16+x^14+x^13+x^11+1, shifting toward the MSB
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // Fold the low nibble into 0..MAX_WAIT by repeated subtraction
    always_comb begin
        w_rand = {1'b0, lfsr[3:0]};
        for (int i = 0; i < 16; i++) begin
            if (w_rand > MW) begin
                w_rand = w_rand - (MW + 5'd1);
            end
        end
    end

    assign w_sel = RAND_EN ? w_rand[3:0] : MW[3:0];

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        capture   = 1'b0;
        enter_ack = 1'b0;
        drop      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (slave_req) begin
                    capture  = 1'b1;
                    wait_nxt = w_sel;
                    if (w_sel == 4'd0) begin
                        state_nxt = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!slave_req) begin
                    drop      = 1'b1;
                    wait_nxt  = 4'd0;
                    state_nxt = S_IDLE;
                end else begin
                    wait_nxt = wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state_nxt = S_ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            lfsr        <= LFSR_SEED;
            slave_rdata <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            proto_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (capture) begin
                lfsr <= lfsr_nxt;
            end
            if (enter_ack) begin
                if (slave_cmd) begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end else begin
                    rd_cnt      <= rd_cnt + CNT_W'(1);
                    slave_rdata <= mem[mem_idx];
                end
            end
            if (drop) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Storage is never reset so contents survive a mid-test reset
    always_ff @(posedge clk) begin
        if (!rst && enter_ack && slave_cmd) begin
            mem[mem_idx] <= slave_wdata;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && enter_ack) begin
            $display("%0t vip_slave id=%0d addr=%h %s data=%h", $time,
                     slave_addr[ADDR_W-1 -: SLAVE_W], slave_addr,
                     slave_cmd ? "WR" : "RD",
                     slave_cmd ? slave_wdata : mem[mem_idx]);
        end
    end
`endif

endmodule
